axi_master_generic: RTL and testbench

//  Synthesizable AXI3 initiator, the counterpart of our generic AXI slave. Takes single

---
 rtl/axi_master_generic_pkg.sv | 29 ++
 rtl/axi_master_generic.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi_master_generic.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_generic_pkg.sv
// Shared types and AXI constants for the generic AXI3 master.
// Response/burst codes live here so the slave-side code can import the same values.
package axi_master_generic_pkg;

    localparam logic [1:0] AXI_RESPONSE_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESPONSE_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESPONSE_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESPONSE_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Response codes are ordered by severity, so the worst is the numeric max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_master_generic.sv
// AXI3 initiator: one burst command at a time, AW/W/B or AR/R, one completion per command.
// Data paths are combinational pass-through gated by the FSM state.
module axi_master_generic
    import axi_master_generic_pkg::*;
#(
    parameter int         ID_W   = 4,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter int         LEN_W  = 4,
    parameter logic [2:0] AXPROT = 3'b000
) (
    input  logic                aclk,
    input  logic                aresetn,
    // command port
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    // local write data
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    // local read data
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_resp,
    output logic                rd_last,
    // completion
    output logic                done_valid,
    output logic                done_write,
    output logic [ID_W-1:0]     done_id,
    output logic [1:0]          done_resp,
    // AXI write address
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awadr,
    output logic [LEN_W-1:0]    awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    // AXI write data
    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wrdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    // AXI write response
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    // AXI read address
    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [LEN_W-1:0]    arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    // AXI read data
    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    localparam int         STRB_W  = DATA_W / 8;
    localparam int         CNT_W   = LEN_W + 1;
    localparam logic [2:0] AX_SIZE = 3'($clog2(STRB_W));

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                write_q, write_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          resp_q, resp_d;
    logic                err_q, err_d;

    logic [CNT_W-1:0]    len_ext;
    logic                beat_err;

    assign len_ext = CNT_W'(len_q);

    assign awsize  = AX_SIZE;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = AXPROT;
    assign arsize  = AX_SIZE;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = AXPROT;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            resp_q  <= AXI_RESPONSE_OKAY;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    // A read beat is bad if its ID is foreign, or rlast disagrees with the beat count.
    assign beat_err = (rid != id_q) || (rlast ? (cnt_q != len_ext) : (cnt_q >= len_ext));

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    id_d    = cmd_id;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    write_d = cmd_write;
                    cnt_d   = '0;
                    resp_d  = AXI_RESPONSE_OKAY;
                    err_d   = 1'b0;
                    state_d = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: if (awready) state_d = ST_WR_DATA;
            ST_WR_DATA: begin
                if (wd_valid && wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_ext) state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    resp_d  = (bid != id_q) ? AXI_RESPONSE_SLVERR : bresp;
                    state_d = ST_DONE;
                end
            end
            ST_RD_ADDR: if (arready) state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (rvalid && rd_ready) begin
                    // Saturate so a runaway burst can never wrap back onto len.
                    cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    resp_d = resp_max(resp_q, rresp);
                    err_d  = err_q | beat_err;
                    if (rlast) begin
                        if (err_q || beat_err) resp_d = AXI_RESPONSE_SLVERR;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        wd_ready   = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        rd_resp    = 2'b00;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        done_write = 1'b0;
        done_id    = '0;
        done_resp  = 2'b00;
        awid       = '0;
        awadr      = '0;
        awlen      = '0;
        awvalid    = 1'b0;
        wid        = '0;
        wrdata     = '0;
        wstrb      = '0;
        wlast      = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        arid       = '0;
        araddr     = '0;
        arlen      = '0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_WR_ADDR: begin
                awid    = id_q;
                awadr   = addr_q;
                awlen   = len_q;
                awvalid = 1'b1;
            end
            ST_WR_DATA: begin
                wid      = id_q;
                wrdata   = wd_data;
                wstrb    = wd_strb;
                wlast    = (cnt_q == len_ext);
                wvalid   = wd_valid;
                wd_ready = wready;
            end
            ST_WR_RESP: bready = 1'b1;
            ST_RD_ADDR: begin
                arid    = id_q;
                araddr  = addr_q;
                arlen   = len_q;
                arvalid = 1'b1;
            end
            ST_RD_DATA: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                rd_data  = rdata;
                rd_resp  = rresp;
                rd_last  = rlast;
            end
            ST_DONE: begin
                done_valid = 1'b1;
                done_write = write_q;
                done_id    = id_q;
                done_resp  = resp_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_master_generic.sv
// Bench for axi_master_generic: table of burst commands against a cycle-level slave model,
// expected beats and completions queued up front and popped as the DUT produces them.
module tb_axi_master_generic;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_last;
    logic        done_valid, done_write;
    logic [3:0]  done_id;
    logic [1:0]  done_resp;
    logic [3:0]  awid;
    logic [31:0] awadr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wrdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    always #5 clk = ~clk;

    axi_master_generic dut (
        .aclk(clk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
        .rd_last(rd_last),
        .done_valid(done_valid), .done_write(done_write), .done_id(done_id),
        .done_resp(done_resp),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    typedef struct {
        bit         wr;
        logic [3:0] id;
        logic [31:0] addr;
        logic [3:0] len;
        int         dly;       // address-channel ready delay in cycles
        bit         thr;       // toggle wready (write) / rd_ready (read)
        logic [3:0] bid;
        logic [1:0] bresp;
        int         err_beat;  // read beat returning SLVERR, -1 for none
        int         sbeats;    // beats the slave returns; rlast on the final one
        logic [3:0] rid;
        logic [1:0] exp_resp;
    } vec_t;

    vec_t        vecs[9];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] wq[$];
    logic [63:0] rq[$];
    logic [63:0] dq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0; arready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    endtask

    task automatic run_vec(input int vi);
        vec_t        v;
        int          nb, cyc, aw_wait, wsent, rsent;
        bit          accepted, aw_done, ar_done, w_done, b_sent, finished;
        logic [31:0] wdat[16];
        logic [3:0]  wst[16];
        logic [63:0] e;
        v = vecs[vi];
        nb = int'(v.len) + 1;
        accepted = 0; aw_done = 0; ar_done = 0; w_done = 0; b_sent = 0; finished = 0;
        aw_wait = 0; wsent = 0; rsent = 0;
        for (int i = 0; i < 16; i++) begin
            wdat[i] = $urandom;
            wst[i]  = 4'($urandom_range(1, 15));
        end
        if (v.wr) begin
            for (int i = 0; i < nb; i++) wq.push_back({23'd0, wdat[i], wst[i], (i == nb - 1), v.id});
        end else begin
            for (int i = 0; i < v.sbeats; i++)
                rq.push_back({29'd0, 32'hA500_0000 | 32'(vi << 8) | 32'(i),
                              (i == v.err_beat) ? 2'b10 : 2'b00, (i == v.sbeats - 1)});
        end
        dq.push_back({57'd0, v.id, v.wr, v.exp_resp});

        for (cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            cmd_valid = 1;
            if (!accepted) begin
                cmd_write = v.wr; cmd_id = v.id; cmd_addr = v.addr; cmd_len = v.len;
            end else begin
                cmd_write = ~v.wr; cmd_id = ~v.id; cmd_addr = 32'hFFFF_FFF0; cmd_len = ~v.len;
            end
            awready  = awvalid && (aw_wait >= v.dly);
            arready  = arvalid && (aw_wait >= v.dly);
            wd_valid = v.wr && accepted && (wsent < nb);
            wd_data  = wdat[wsent % 16];
            wd_strb  = wst[wsent % 16];
            wready   = v.thr ? (cyc % 2 == 0) : 1'b1;
            bvalid   = w_done && !b_sent;
            bid      = v.bid;
            bresp    = v.bresp;
            rvalid   = ar_done && (rsent < v.sbeats);
            rid      = v.rid;
            rdata    = 32'hA500_0000 | 32'(vi << 8) | 32'(rsent);
            rresp    = (rsent == v.err_beat) ? 2'b10 : 2'b00;
            rlast    = (rsent == v.sbeats - 1);
            rd_ready = v.thr ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (cyc == 0) chk("idle_ready", {cmd_ready, done_valid}, 2'b10);
            if (accepted) chk("cmd_ignored", cmd_ready, 0);
            chk("aw_ar_chan", v.wr ? arvalid : awvalid, 0);
            if (v.wr) chk("w_before_aw", wvalid && !aw_done, 0);
            if (awvalid)
                chk("aw_fields", {awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot},
                    {v.id, v.addr, v.len, 3'd2, 2'b01, 2'b00, 4'h0, 3'b000});
            if (arvalid)
                chk("ar_fields", {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot},
                    {v.id, v.addr, v.len, 3'd2, 2'b01, 2'b00, 4'h0, 3'b000});
            if (wvalid && wready) begin
                e = (wq.size() > 0) ? wq.pop_front() : 64'hDEAD;
                chk("w_beat", {23'd0, wrdata, wstrb, wlast, wid}, e);
                chk("wd_ready", wd_ready, 1);
                wsent++;
                if (wsent == nb) w_done = 1;
            end
            if (rd_valid && rd_ready) begin
                e = (rq.size() > 0) ? rq.pop_front() : 64'hDEAD;
                chk("rd_beat", {29'd0, rd_data, rd_resp, rd_last}, e);
                chk("rready", rready, 1);
            end
            if (rvalid && rready) rsent++;
            if (bvalid && bready) b_sent = 1;
            if (awvalid || arvalid) aw_wait++;
            if (awvalid && awready) aw_done = 1;
            if (arvalid && arready) ar_done = 1;
            if (done_valid) begin
                e = (dq.size() > 0) ? dq.pop_front() : 64'hDEAD;
                chk("done", {57'd0, done_id, done_write, done_resp}, e);
                finished = 1;
            end
            if (cmd_valid && cmd_ready && !accepted) accepted = 1;
            if (cyc == 0) chk("accept_first_cycle", accepted, 1);
        end
        if (!finished) chk("timeout", 0, 1);
        chk("w_left", wq.size(), 0);
        chk("r_left", rq.size(), 0);
        $display("txn %0d wr=%0d id=%0h len=%0d resp=%0b cycles=%0d", vi, v.wr, v.id, v.len,
                 v.exp_resp, cyc);
        wq.delete(); rq.delete(); dq.delete();
    endtask

    initial begin
        vecs[0] = '{1, 4'd3,  32'h10,  4'd0,  0, 0, 4'd3, 2'b00, -1, 0, 4'd0,  2'b00};
        vecs[1] = '{1, 4'd2,  32'h100, 4'd3,  3, 1, 4'd2, 2'b00, -1, 0, 4'd0,  2'b00};
        vecs[2] = '{0, 4'd5,  32'h40,  4'd7,  0, 1, 4'd0, 2'b00,  4, 8, 4'd5,  2'b10};
        vecs[3] = '{0, 4'd1,  32'h80,  4'd3,  0, 0, 4'd0, 2'b00, -1, 3, 4'd1,  2'b10};
        vecs[4] = '{1, 4'd6,  32'h200, 4'd1,  1, 0, 4'd7, 2'b00, -1, 0, 4'd0,  2'b10};
        vecs[5] = '{1, 4'd4,  32'h300, 4'd15, 0, 1, 4'd4, 2'b01, -1, 0, 4'd0,  2'b01};
        vecs[6] = '{0, 4'd9,  32'h400, 4'd1,  2, 0, 4'd0, 2'b00, -1, 2, 4'd8,  2'b10};
        vecs[7] = '{0, 4'd7,  32'h500, 4'd2,  0, 1, 4'd0, 2'b00, -1, 3, 4'd7,  2'b00};
        vecs[8] = '{0, 4'd10, 32'h600, 4'd1,  0, 0, 4'd0, 2'b00, -1, 3, 4'd10, 2'b10};

        clear_inputs();
        aresetn = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valids", {awvalid, wvalid, bready, arvalid, rready, rd_valid, wd_ready,
                             done_valid, cmd_ready}, 9'b000000001);
        chk("reset_fields", {awid, awadr, awlen, arid, araddr, arlen}, 0);
        @(negedge clk);
        aresetn = 1;

        for (int i = 0; i < 9; i++) run_vec(i);
        @(negedge clk);
        clear_inputs();

        // Reset landing between clock edges while a write beat is on offer.
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_id = 4'hC; cmd_addr = 32'h700; cmd_len = 4'd3;
        @(negedge clk);
        cmd_valid = 0; awready = 1;
        @(negedge clk);
        awready = 0; wd_valid = 1; wd_data = 32'h1234_5678; wd_strb = 4'hF; wready = 1;
        #1;
        chk("pre_reset_w", {wvalid, wd_ready, wrdata}, {2'b11, 32'h1234_5678});
        #1;
        aresetn = 0;
        #1;
        chk("midreset_valids", {awvalid, wvalid, bready, arvalid, rready, rd_valid, wd_ready,
                                done_valid, cmd_ready}, 9'b000000001);
        chk("midreset_data", {wid, wrdata, wstrb, wlast}, 0);
        $display("txn reset mid-write wvalid=%0b cmd_ready=%0b", wvalid, cmd_ready);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        aresetn = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("no_done_after_reset", {done_valid, cmd_ready, awvalid}, 3'b010);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
